usb_uart_stream_fifo: RTL and testbench
=======================================

// Module: usb_uart_stream_fifo
// PURPOSE
//  UART-side stage of the USB CDC bridge. Buffers a byte stream bound for the host and drives the
//  bridge's strobe/wait port (uart_we/uart_re/uart_di/uart_do/uart_wait). Polls the bridge for
//  host-sent bytes and delivers them as a valid/ready stream. Sits between a physical UART or CPU core and the bridge.
// PARAMETERS
//  TX_DEPTH       16  host-bound FIFO depth, power of 2, >=2
//  RX_DEPTH       16  device-bound FIFO depth, power of 2, >=2
//  POLL_INTERVAL  8   idle cycles before re-polling after a read that returned no data (1..255)
//  RD_SAMPLE_DLY  2   cycles from first uart_wait=1 of a read to the uart_do capture edge
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high
//  in_data    in   8   byte to send to host
//  in_valid   in   1   in_data valid
//  in_ready   out  1   = TX FIFO not full; transfer on in_valid&in_ready
//  out_data   out  8   byte received from host (RX FIFO head)
//  out_valid  out  1   = RX FIFO not empty
//  out_ready  in   1   consumer pops on out_valid&out_ready
//  uart_we    out  1   one-cycle write strobe to bridge
//  uart_re    out  1   one-cycle read strobe to bridge
//  uart_di    out  8   write byte, held from strobe until write completes
//  uart_do    in   8   read byte from bridge
//  uart_wait  in   1   bridge busy
//  tx_level   out  clog2(TX_DEPTH)+1  TX FIFO occupancy
//  rx_level   out  clog2(RX_DEPTH)+1  RX FIFO occupancy
// BEHAVIOUR
//  Reset: FIFOs empty, FSM=IDLE, uart_we=uart_re=0, uart_di=0, out_valid=0, in_ready=1, poll timer=0.
//  FSM (one bridge transaction in flight at most):
//   IDLE: wr_ok=TX non-empty; rd_ok=RX has >=1 free entry & poll timer=0.
//     Both ok: alternate, starting with write after reset. Otherwise take the one that is ok.
//   WR_STROBE: uart_we=1, uart_di=TX head -> WR_WAIT.
//   WR_WAIT: on uart_wait=0, pop TX -> GAP. No timeout: stalls while host does not read IN.
//   RD_STROBE: uart_re=1 -> RD_CHECK.
//   RD_CHECK: uart_wait=1 -> RD_WAIT, start sample count.
//     uart_wait=0 (no host data): load poll timer=POLL_INTERVAL -> GAP.
//   RD_WAIT: capture uart_do into RX at cycle RD_SAMPLE_DLY after RD_CHECK -> GAP.
//   GAP: 1 cycle, lets bridge return to idle -> IDLE.
//  Poll timer decrements once per cycle when non-zero. Only an empty read loads it.
//  Write latency: strobe 1 cycle after IDLE sees wr_ok. Exact cycle count depends on bridge wait.
//  No RX overflow: a read is issued only with RX space reserved.
//  FIFO pop during the read-capture cycle is legal.
//  FIFO rules: same-cycle push+pop on full TX is not accepted, because in_ready is registered-full-based.
//  On empty RX, pop is ignored. Pointers wrap modulo depth.
//  Reset mid-transaction: abandons the transaction, FIFO contents lost. Bridge must share the reset.
//  uart_we and uart_re are never high in the same cycle.
// CONFIGURATION
//  USB_UART_FIFO_STATS_EN defined: adds outputs stat_tx_bytes[15:0], stat_rx_bytes[15:0], stat_poll_miss[15:0].
//   These count completed writes, captured reads and empty reads. Counters saturate at 16'hFFFF and are cleared by reset.
//  Undefined: ports and counters absent. All other behaviour is identical.
// STRUCTURE
//  usb_uart_pkg: FSM state enum, STATE_W, GAP_CYCLES=1.
//  Sub-module usb_uart_sync_fifo (WIDTH, DEPTH), instantiated for TX and RX. Provides level, full and empty.
// TESTING
//  1 Push 0x41,0x42,0x43 with bridge model idle.
//    Expect three uart_we pulses, uart_di=41,42,43 in order, each separated by >=2 cycles after wait falls.
//  2 Model holds host byte 0x5A. Expect uart_re, wait=1 for 1 cycle, then out_data=5A, out_valid=1 RD_SAMPLE_DLY+2 cycles later.
//  3 Model has no host data. Expect uart_re, then no further uart_re for POLL_INTERVAL+1 cycles. stat_poll_miss increments.
//  4 TX non-empty and host byte pending. Expect alternating write/read transactions, never we&re together.
//  5 Fill RX to 16 with out_ready=0. Expect no uart_re while full. Pop one, then one read is issued.
//  6 Assert reset during WR_WAIT. Expect uart_we=uart_re=0, tx_level=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/usb_uart_pkg.sv
// Shared types and constants for the USB CDC bridge UART-side stage.
// Bridge transaction FSM states, gap length and a saturating counter helper.
package usb_uart_pkg;

    localparam int STATE_W    = 3;
    localparam int GAP_CYCLES = 1;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_WR_STROBE,
        S_WR_WAIT,
        S_RD_STROBE,
        S_RD_CHECK,
        S_RD_WAIT,
        S_GAP
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/usb_uart_sync_fifo.sv
// Single-clock FIFO with occupancy level; push ignored when full, pop ignored when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module usb_uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q[AW];
    assign empty = (cnt_q == '0);
    assign level = cnt_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/usb_uart_stream_fifo.sv
// UART-side stage of the USB CDC bridge: TX/RX byte FIFOs plus bridge strobe/wait sequencer.
// Define USB_UART_FIFO_STATS_EN to add saturating transfer/poll-miss counters.
module usb_uart_stream_fifo
    import usb_uart_pkg::*;
#(
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 16,
    parameter int POLL_INTERVAL = 8,
    parameter int RD_SAMPLE_DLY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      uart_we,
    output logic                      uart_re,
    output logic [7:0]                uart_di,
    input  logic [7:0]                uart_do,
    input  logic                      uart_wait,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [$clog2(RX_DEPTH):0] rx_level
`ifdef USB_UART_FIFO_STATS_EN
    ,
    output logic [15:0]               stat_tx_bytes,
    output logic [15:0]               stat_rx_bytes,
    output logic [15:0]               stat_poll_miss
`endif
);

    state_e     state_q, state_d;
    logic       prefer_wr_q, prefer_wr_d;
    logic [7:0] uart_di_q, uart_di_d;
    logic [7:0] smp_cnt_q, smp_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] poll_q, poll_d;

    logic [7:0] tx_head, rx_head;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_pop, rx_push;
    logic       wr_ok, rd_ok;

    assign in_ready  = ~tx_full;
    assign out_valid = ~rx_empty;
    assign out_data  = rx_head;
    assign uart_di   = uart_di_q;
    assign wr_ok     = ~tx_empty;
    assign rd_ok     = ~rx_full & (poll_q == '0);

    usb_uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    usb_uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (uart_do),
        .pop       (out_ready),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    always_comb begin
        state_d     = state_q;
        prefer_wr_d = prefer_wr_q;
        uart_di_d   = uart_di_q;
        smp_cnt_d   = smp_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        poll_d      = (poll_q != '0) ? poll_q - 8'd1 : poll_q;
        uart_we     = 1'b0;
        uart_re     = 1'b0;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Arbitration flips after every issued transaction
                if (wr_ok && (!rd_ok || prefer_wr_q)) begin
                    state_d     = S_WR_STROBE;
                    uart_di_d   = tx_head;
                    prefer_wr_d = 1'b0;
                end else if (rd_ok) begin
                    state_d     = S_RD_STROBE;
                    prefer_wr_d = 1'b1;
                end
            end
            S_WR_STROBE: begin
                uart_we = 1'b1;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!uart_wait) begin
                    tx_pop    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_RD_STROBE: begin
                uart_re = 1'b1;
                state_d = S_RD_CHECK;
            end
            S_RD_CHECK: begin
                if (uart_wait) begin
                    smp_cnt_d = 8'd1;
                    state_d   = S_RD_WAIT;
                end else begin
                    poll_d    = 8'(POLL_INTERVAL);
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_RD_WAIT: begin
                if (smp_cnt_q == 8'(RD_SAMPLE_DLY)) begin
                    rx_push   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    smp_cnt_d = smp_cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else gap_cnt_d = gap_cnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prefer_wr_q <= 1'b1;
            uart_di_q   <= '0;
            smp_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            poll_q      <= '0;
        end else begin
            state_q     <= state_d;
            prefer_wr_q <= prefer_wr_d;
            uart_di_q   <= uart_di_d;
            smp_cnt_q   <= smp_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            poll_q      <= poll_d;
        end
    end

`ifdef USB_UART_FIFO_STATS_EN
    logic [15:0] st_tx_q, st_tx_d;
    logic [15:0] st_rx_q, st_rx_d;
    logic [15:0] st_miss_q, st_miss_d;

    always_comb begin
        st_tx_d   = sat_inc(st_tx_q, tx_pop);
        st_rx_d   = sat_inc(st_rx_q, rx_push);
        st_miss_d = sat_inc(st_miss_q, (state_q == S_RD_CHECK) & ~uart_wait);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_tx_q   <= '0;
            st_rx_q   <= '0;
            st_miss_q <= '0;
        end else begin
            st_tx_q   <= st_tx_d;
            st_rx_q   <= st_rx_d;
            st_miss_q <= st_miss_d;
        end
    end

    assign stat_tx_bytes  = st_tx_q;
    assign stat_rx_bytes  = st_rx_q;
    assign stat_poll_miss = st_miss_q;
`endif

endmodule

// File: tb/tb_usb_uart_stream_fifo.sv
// Scoreboard bench for usb_uart_stream_fifo with a behavioural CDC bridge model.
// Stimulus drives at negedge; the monitor samples 1ns after negedge.
`timescale 1ns/1ps
module tb_usb_uart_stream_fifo;

    localparam int TX_DEPTH      = 16;
    localparam int RX_DEPTH      = 16;
    localparam int POLL_INTERVAL = 8;
    localparam int RD_SAMPLE_DLY = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       uart_we, uart_re;
    logic [7:0] uart_di;
    logic [7:0] uart_do = '0;
    logic       uart_wait = 1'b0;
    logic [4:0] tx_level, rx_level;
`ifdef USB_UART_FIFO_STATS_EN
    logic [15:0] stat_tx_bytes, stat_rx_bytes, stat_poll_miss;
`endif

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] host_q[$];
    bit         txn_log[$];
    bit         log_en = 1'b0;

    int wr_hold = 1;
    int rd_hold = 1;

    usb_uart_stream_fifo #(
        .TX_DEPTH      (TX_DEPTH),
        .RX_DEPTH      (RX_DEPTH),
        .POLL_INTERVAL (POLL_INTERVAL),
        .RD_SAMPLE_DLY (RD_SAMPLE_DLY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .uart_we   (uart_we),
        .uart_re   (uart_re),
        .uart_di   (uart_di),
        .uart_do   (uart_do),
        .uart_wait (uart_wait),
        .tx_level  (tx_level),
        .rx_level  (rx_level)
`ifdef USB_UART_FIFO_STATS_EN
        ,
        .stat_tx_bytes  (stat_tx_bytes),
        .stat_rx_bytes  (stat_rx_bytes),
        .stat_poll_miss (stat_poll_miss)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, ncyc);
        end
    endfunction

    // Bridge model: wait rises the cycle after a strobe; host bytes come from host_q
    int  wcnt = 0;
    bit  miss_vld = 1'b0;
    int  miss_cyc = 0;
    always @(posedge clk) begin
        if (reset) begin
            uart_wait <= 1'b0;
            wcnt = 0;
            miss_vld = 1'b0;
        end else if (uart_we) begin
            uart_wait <= 1'b1;
            wcnt = wr_hold;
        end else if (uart_re) begin
            if (host_q.size() > 0) begin
                logic [7:0] b;
                b = host_q.pop_front();
                uart_do <= b;
                exp_rx.push_back(b);
                uart_wait <= 1'b1;
                wcnt = rd_hold;
            end else begin
                miss_vld = 1'b1;
                miss_cyc = ncyc;
            end
        end else if (wcnt > 1) begin
            wcnt--;
        end else begin
            wcnt = 0;
            uart_wait <= 1'b0;
        end
    end

    int last_busy = 0;
    bit busy_vld  = 1'b0;
    always @(negedge clk) begin
        #1;
        ncyc++;
        if (reset) begin
            busy_vld = 1'b0;
        end else begin
            if (uart_we || uart_re)
                chk(!(uart_we && uart_re), "we_re_excl", {uart_we, uart_re}, 0);
            if ((uart_we || uart_re) && busy_vld)
                chk(ncyc - last_busy >= 3, "strobe_spacing", ncyc - last_busy, 3);
            if (uart_we) begin
                if (log_en) txn_log.push_back(1'b1);
                chk(exp_tx.size() > 0, "wr_expected", exp_tx.size(), 1);
                if (exp_tx.size() > 0) begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    chk(uart_di == e, "uart_di", uart_di, e);
                end
            end
            if (uart_re) begin
                if (log_en) txn_log.push_back(1'b0);
                chk(rx_level < RX_DEPTH, "rd_space", rx_level, RX_DEPTH - 1);
                if (miss_vld)
                    chk(ncyc - miss_cyc >= POLL_INTERVAL + 2, "poll_gap",
                        ncyc - miss_cyc, POLL_INTERVAL + 2);
            end
            if (out_valid && out_ready) begin
                chk(exp_rx.size() > 0, "rx_expected", exp_rx.size(), 1);
                if (exp_rx.size() > 0) begin
                    logic [7:0] e;
                    e = exp_rx.pop_front();
                    chk(out_data == e, "out_data", out_data, e);
                end
            end
            if (uart_wait) begin
                last_busy = ncyc;
                busy_vld  = 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int g = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk(g < 2000, "in_ready_timeout", g, 2000);
        exp_tx.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || host_q.size() != 0 || exp_rx.size() != 0 || out_valid)
               && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(n < limit, name, n, limit);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk(uart_we == 1'b0, "rst_we", uart_we, 0);
        chk(uart_re == 1'b0, "rst_re", uart_re, 0);
        chk(uart_di == 8'h00, "rst_di", uart_di, 0);
        chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(tx_level == 5'd0, "rst_tx_level", tx_level, 0);
        chk(rx_level == 5'd0, "rst_rx_level", rx_level, 0);
`ifdef USB_UART_FIFO_STATS_EN
        chk(stat_poll_miss == 16'd0, "rst_stat_miss", stat_poll_miss, 0);
`endif
        reset = 1'b0;

        // Three host-bound bytes in order
        out_ready = 1'b1;
        send(8'h41);
        send(8'h42);
        send(8'h43);
        wait_idle(500, "t1_drain");

        // One host byte: capture latency measured from the read strobe
        out_ready = 1'b0;
        chk(out_valid == 1'b0, "t2_rx_empty", out_valid, 0);
        host_q.push_back(8'h5A);
        n = 0;
        while (!uart_re && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(n < 200, "t2_re_seen", n, 200);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk(n == RD_SAMPLE_DLY + 2, "t2_latency", n, RD_SAMPLE_DLY + 2);
        chk(out_data == 8'h5A, "t2_data", out_data, 8'h5A);
        out_ready = 1'b1;
        @(negedge clk);
        wait_idle(200, "t2_drain");

        // Empty read backs off for the poll interval
        n = 0;
        while (!uart_re && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(n < 100, "t3_re_seen", n, 100);
        begin
`ifdef USB_UART_FIFO_STATS_EN
            int m0;
            m0 = int'(stat_poll_miss);
`endif
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!uart_re && n < 100);
            chk(n >= POLL_INTERVAL + 2 && n < 100, "t3_poll_gap", n, POLL_INTERVAL + 2);
`ifdef USB_UART_FIFO_STATS_EN
            chk(int'(stat_poll_miss) == m0 + 1, "t3_stat_miss", stat_poll_miss, m0 + 1);
`endif
        end

        // Writes and reads alternate while both have work
        for (int i = 0; i < 12; i++) host_q.push_back(8'(8'hA0 + i));
        n = 0;
        while (host_q.size() == 12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(n < 100, "t4_first_read", n, 100);
        log_en = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
        n = 0;
        while (exp_tx.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        log_en = 1'b0;
        chk(n < 300, "t4_tx_done", n, 300);
        begin
            bit seen_w = 1'b0;
            bit rd_between = 1'b0;
            foreach (txn_log[i]) begin
                if (txn_log[i]) begin
                    if (seen_w) chk(rd_between, "t4_alternate", rd_between, 1);
                    seen_w = 1'b1;
                    rd_between = 1'b0;
                end else begin
                    rd_between = 1'b1;
                end
            end
        end
        wait_idle(500, "t4_drain");

        // RX full blocks reads until one entry is freed
        out_ready = 1'b0;
        for (int i = 0; i < RX_DEPTH + 1; i++) host_q.push_back(8'($urandom));
        n = 0;
        while (rx_level != 5'(RX_DEPTH) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(n < 600, "t5_fill", rx_level, RX_DEPTH);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (uart_re) n++;
        end
        chk(n == 0, "t5_no_re_full", n, 0);
        chk(rx_level == 5'(RX_DEPTH), "t5_level_hold", rx_level, RX_DEPTH);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n = 0;
        while (!uart_re && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(n < 40, "t5_re_after_pop", n, 40);
        out_ready = 1'b1;
        wait_idle(500, "t5_drain");

        // Reset while a write is stalled on the bridge
        wr_hold = 50;
        send(8'hC3);
        n = 0;
        while (!uart_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(n < 100, "t6_we_seen", n, 100);
        send(8'hC4);
        send(8'hC5);
        chk(tx_level == 5'd3, "t6_tx_level_pre", tx_level, 3);
        reset = 1'b1;
        @(negedge clk);
        chk(uart_we == 1'b0, "t6_we", uart_we, 0);
        chk(uart_re == 1'b0, "t6_re", uart_re, 0);
        chk(tx_level == 5'd0, "t6_tx_level", tx_level, 0);
        chk(in_ready == 1'b1, "t6_in_ready", in_ready, 1);
        exp_tx.delete();
        exp_rx.delete();
        host_q.delete();
        wr_hold = 1;
        reset = 1'b0;

        // Randomised traffic in both directions
        for (int it = 0; it < 400; it++) begin
            wr_hold   = $urandom_range(1, 4);
            rd_hold   = $urandom_range(1, 3);
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) host_q.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0) send(8'($urandom));
            else @(negedge clk);
        end
        out_ready = 1'b1;
        wait_idle(3000, "rand_drain");
        chk(exp_tx.size() == 0, "final_tx_queue", exp_tx.size(), 0);
        chk(exp_rx.size() == 0, "final_rx_queue", exp_rx.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
